// File: rtl/count_sequencer.sv
// count_sequencer: control and count stage behind the button debouncers.
//
// Detects rising edges on the debounced progressive/regressive/start levels, runs a
// run/pause/direction FSM and steps a 2-digit BCD up/down counter once every TICK_DIV
// clocks while running.
//
// Parameters
//   TICK_DIV   clocks per count step while running (>= 2)
//   MAX_COUNT  top count value, decimal, 1..99
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-low reset
//   progressive  in   debounced level; rising edge selects count-up
//   regressive   in   debounced level; rising edge selects count-down
//   start        in   debounced level; rising edge starts/pauses/resumes
//   units        out  BCD units digit of the count
//   tens         out  BCD tens digit of the count
//   running      out  1 while the FSM is in RUN
//   dir_up       out  1 = counting up, 0 = counting down
//   step         out  one-cycle pulse on every count change
//
// Build option
//   COUNT_SATURATE_EN  when defined, the count holds at MAX_COUNT (up) or 00 (down)
//                      instead of wrapping, and the FSM drops back to IDLE on that tick.

module count_sequencer #(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned MAX_COUNT = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       progressive,
    input  logic       regressive,
    input  logic       start,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic       running,
    output logic       dir_up,
    output logic       step
);

    localparam int unsigned     PrescW    = $clog2(TICK_DIV);
    localparam logic [PrescW-1:0] PrescLast = PrescW'(TICK_DIV - 1);
    localparam logic [3:0]      MaxTens   = 4'(MAX_COUNT / 10);
    localparam logic [3:0]      MaxUnits  = 4'(MAX_COUNT % 10);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPaused
    } state_e;

    state_e            state_q, state_d;
    logic [PrescW-1:0] presc_q, presc_d;
    logic [3:0]        units_q, units_d;
    logic [3:0]        tens_q, tens_d;
    logic              dir_up_q, dir_up_d;
    logic              step_q, step_d;
    logic              prog_prev_q, prog_prev_d;
    logic              regr_prev_q, regr_prev_d;
    logic              start_prev_q, start_prev_d;

    logic prog_rise, regr_rise, start_rise;
    logic tick;
    logic at_max, at_zero;

    assign prog_rise  = progressive & ~prog_prev_q;
    assign regr_rise  = regressive & ~regr_prev_q;
    assign start_rise = start & ~start_prev_q;

    assign at_max  = (tens_q == MaxTens) && (units_q == MaxUnits);
    assign at_zero = (tens_q == 4'd0) && (units_q == 4'd0);

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        units_d      = units_q;
        tens_d       = tens_q;
        dir_up_d     = dir_up_q;
        step_d       = 1'b0;
        tick         = 1'b0;
        prog_prev_d  = progressive;
        regr_prev_d  = regressive;
        start_prev_d = start;

        // Simultaneous progressive/regressive rises cancel out.
        if (prog_rise && !regr_rise) begin
            dir_up_d = 1'b1;
        end else if (regr_rise && !prog_rise) begin
            dir_up_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start_rise) begin
                    state_d = StRun;
                    presc_d = '0;
                end
            end
            StRun: begin
                if (presc_q == PrescLast) begin
                    presc_d = '0;
                    tick    = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
                if (start_rise) begin
                    state_d = StPaused;
                end
            end
            StPaused: begin
                if (start_rise) begin
                    state_d = StRun;
                    presc_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // The step uses the direction in force before this edge; any start transition
        // decided above lands on the same edge.
        if (tick) begin
            if (dir_up_q) begin
                if (at_max) begin
`ifdef COUNT_SATURATE_EN
                    state_d = StIdle;
`else
                    units_d = 4'd0;
                    tens_d  = 4'd0;
                    step_d  = 1'b1;
`endif
                end else if (units_q == 4'd9) begin
                    units_d = 4'd0;
                    tens_d  = tens_q + 4'd1;
                    step_d  = 1'b1;
                end else begin
                    units_d = units_q + 4'd1;
                    step_d  = 1'b1;
                end
            end else begin
                if (at_zero) begin
`ifdef COUNT_SATURATE_EN
                    state_d = StIdle;
`else
                    units_d = MaxUnits;
                    tens_d  = MaxTens;
                    step_d  = 1'b1;
`endif
                end else if (units_q == 4'd0) begin
                    units_d = 4'd9;
                    tens_d  = tens_q - 4'd1;
                    step_d  = 1'b1;
                end else begin
                    units_d = units_q - 4'd1;
                    step_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            presc_q      <= '0;
            units_q      <= 4'd0;
            tens_q       <= 4'd0;
            dir_up_q     <= 1'b1;
            step_q       <= 1'b0;
            prog_prev_q  <= 1'b0;
            regr_prev_q  <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            units_q      <= units_d;
            tens_q       <= tens_d;
            dir_up_q     <= dir_up_d;
            step_q       <= step_d;
            prog_prev_q  <= prog_prev_d;
            regr_prev_q  <= regr_prev_d;
            start_prev_q <= start_prev_d;
        end
    end

    assign units   = units_q;
    assign tens    = tens_q;
    assign running = (state_q == StRun);
    assign dir_up  = dir_up_q;
    assign step    = step_q;

endmodule
